// File: rtl/adder_pipe.sv
// Purpose : WIDTH-bit a+b+cin, split into STAGES carry-chained chunks of CW bits, one chunk per stage.
// Latency : STAGES cycles from accept to out_valid when not stalled; each stall cycle adds one.
// Backpr. : elastic valid/ready, bubbles collapse; in_ready falls only when every stage is full and out_ready=0.
//
// Ports:
//   clk, rst_n           clock (rising edge) and asynchronous active-low reset
//   in_valid/in_ready    operand beat handshake (a, b, cin)
//   out_valid/out_ready  result beat handshake (sum, cout[, ovf])
//   sum, cout            registered {cout,sum} = a + b + cin
// Optional: define ADDER_PIPE_OVF_EN to add output ovf, the registered two's-complement overflow
//           of a+b+cin, which travels with its beat.
module adder_pipe #(
   parameter int WIDTH  = 16,   // must be a multiple of STAGES
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef ADDER_PIPE_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = WIDTH / STAGES;

   // One pipeline stage. After stage k, sum_dat holds resolved chunks 0..k, cy is the carry
   // into chunk k+1, and a_dat/b_dat still carry the unconsumed chunks k+1.. (lower chunks of
   // the operands are dead by then and get trimmed away in synthesis).
   typedef struct packed {
      logic             vld;
      logic [WIDTH-1:0] a_dat;
      logic [WIDTH-1:0] b_dat;
      logic [WIDTH-1:0] sum_dat;
      logic             cy;
`ifdef ADDER_PIPE_OVF_EN
      logic             ovf;
`endif
   } stage_t;

   stage_t            st_q  [STAGES];
   stage_t            nxt_a [STAGES];
   logic [STAGES-1:0] rdy;

   // Stage k may load when it, or any stage below it, has a free slot, or the consumer pops.
   // This is the unrolled form of rdy[k] = !v[k] | rdy[k+1] with rdy[STAGES] = out_ready,
   // written without a self-referencing vector so the chain stays a clean combinational cone.
   always_comb begin
      rdy = '0;
      for (int k = 0; k < STAGES; k++) begin
         rdy[k] = out_ready;
         for (int j = k; j < STAGES; j++) begin
            if (!st_q[j].vld) begin
               rdy[k] = 1'b1;
            end
         end
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      stage_t      up_s;
      stage_t      nxt_s;
      logic [CW:0] ch;

      if (k == 0) begin : g_head
         always_comb begin
            up_s       = '0;
            up_s.vld   = in_valid;
            up_s.a_dat = a;
            up_s.b_dat = b;
            up_s.cy    = cin;
         end
      end else begin : g_body
         assign up_s = st_q[k-1];
      end

      assign ch = {1'b0, up_s.a_dat[k*CW +: CW]}
                + {1'b0, up_s.b_dat[k*CW +: CW]}
                + {{CW{1'b0}}, up_s.cy};

      always_comb begin
         nxt_s                      = up_s;
         nxt_s.sum_dat[k*CW +: CW]  = ch[CW-1:0];
         nxt_s.cy                   = ch[CW];
`ifdef ADDER_PIPE_OVF_EN
         // The last stage resolves the sum MSB, so it is the first place overflow is known.
         if (k == STAGES-1) begin
            nxt_s.ovf = (up_s.a_dat[WIDTH-1] == up_s.b_dat[WIDTH-1]) &&
                        (ch[CW-1] != up_s.a_dat[WIDTH-1]);
         end
`endif
      end

      assign nxt_a[k] = nxt_s;
   end

   // Payload only loads with a valid beat, so idle junk on a/b never reaches the registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < STAGES; k++) begin
            st_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (rdy[k]) begin
               if (nxt_a[k].vld) begin
                  st_q[k] <= nxt_a[k];
               end else begin
                  st_q[k].vld <= 1'b0;
               end
            end
         end
      end
   end

   assign in_ready  = rdy[0];
   assign out_valid = st_q[STAGES-1].vld;
   assign sum       = st_q[STAGES-1].sum_dat;
   assign cout      = st_q[STAGES-1].cy;
`ifdef ADDER_PIPE_OVF_EN
   assign ovf       = st_q[STAGES-1].ovf;
`endif

endmodule

// File: doc/adder_pipe.md
Name: adder_pipe

Overview:
- Parametrised, pipelined successor to the 4-bit ripple adder: WIDTH-bit a + b + cin split into STAGES equal carry-chained chunks, one chunk resolved per pipeline stage.
- Elastic valid/ready on input and output; full throughput of one add per cycle; lossless backpressure.
- Used wherever wide adds must close timing. Its results are checked against the same a+b+cin arithmetic model as the 4-bit adder.

Parameters:
- WIDTH, 16, operand/sum width in bits; must be a multiple of STAGES.
- STAGES, 4, pipeline depth and chunk count; chunk width CW = WIDTH/STAGES; STAGES=1 is legal (single registered adder).

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand beat present
- in_ready  out  1  pipeline can accept a beat this cycle
- a  in  WIDTH  operand A (unsigned)
- b  in  WIDTH  operand B (unsigned)
- cin  in  1  carry-in
- out_valid  out  1  result beat present
- out_ready  in  1  consumer accepts result this cycle
- sum  out  WIDTH  registered result bits [WIDTH-1:0]
- cout  out  1  registered carry-out (bit WIDTH of a+b+cin)

Behaviour:
- Reset: while rst_n=0, all stage valid bits clear, out_valid=0, sum=0, cout=0 (also ovf=0 when enabled). Takes effect immediately, independent of clk. In-flight beats are discarded, not flushed.
- Stage k (0..STAGES-1) holds the following registers:
  - valid bit v[k].
  - Resolved sum chunks 0..k.
  - Carry out of chunk k.
  - Unconsumed operand chunks k+1..STAGES-1.
- Stage k computes chunk k = a_chunk + b_chunk + carry. The carry is cin for k=0, otherwise the registered carry from stage k-1.
- Ready chain: rdy[STAGES]=out_ready; rdy[k] = !v[k] | rdy[k+1]; in_ready = rdy[0]. The chain is combinational from out_ready.
- Transfer: stage k loads from its upstream when rdy[k]=1, and v[k] takes the upstream valid (in_valid for k=0). If rdy[k]=0, stage k holds its contents unchanged.
- Output: out_valid = v[STAGES-1]; sum/cout come straight from the last-stage registers. They remain stable while out_valid=1 and out_ready=0.
- Latency: a beat accepted in cycle c (in_valid & in_ready) drives out_valid=1 in cycle c+STAGES when there is no stall. Each stall cycle adds one cycle.
- Throughput: 1 beat/cycle with out_ready=1. Capacity is STAGES beats. Beats stay in order with no drops or duplicates.
- Pipeline full with out_ready=0: in_ready=0. A beat offered then must be held by the producer; values of a/b/cin are don't-care while in_valid=0.
- Simultaneous pop and push on a full pipeline: in_ready=1 and both occur in the same cycle.
- Arithmetic: {cout,sum} = a + b + cin, exact (WIDTH+1 bits) for all inputs, including all-ones wrap: sum=0, cout=1.
- No internal state other than the stage registers; no X may reach the outputs after reset.

Optional Feature:
- Macro ADDER_PIPE_OVF_EN.
- Defined: adds port ovf (out, 1), the registered two's-complement signed overflow of a+b+cin: operands' MSBs equal and sum MSB differs. It travels with its beat, resets to 0, and is held under stall.
- Undefined: no ovf port and no overflow logic; all other behaviour is identical.

Test Plan:
- WIDTH=16, STAGES=4, out_ready=1: a=16'hFFFF, b=16'h0001, cin=0 accepted in cycle c -> out_valid first high in cycle c+4 with sum=16'h0000, cout=1.
- Back-to-back burst of 3 beats: (1,2,0), (16'h00FF,16'h0001,1), (16'h8000,16'h8000,0) -> outputs on consecutive cycles: 3/0, 16'h0101/0, 16'h0000/1.
- out_ready=0 while feeding 6 beats -> in_ready drops after exactly 4 accepted. Raise out_ready -> all 6 results emerge in order; sum/cout are stable during every stall cycle.
- Assert rst_n=0 asynchronously with 3 beats in flight -> out_valid, sum, cout go to 0 before the next edge. After release, no stale beat appears; the first new beat has latency 4.
- With ADDER_PIPE_OVF_EN defined: a=16'h7FFF, b=16'h0001, cin=0 -> sum=16'h8000, cout=0, ovf=1. Then a=16'h8000, b=16'hFFFF, cin=0 -> sum=16'h7FFF, cout=1, ovf=1.
- 1000 random beats with random in_valid/out_ready toggling, run with STAGES=1 and STAGES=4 -> every result matches a+b+cin and the beat count matches. Any mismatch ends in $fatal(1).
